// File: rtl/ahb_slave_port_mux_pkg.sv
// rtl/ahb_slave_port_mux_pkg.sv - shared AHB types and defaults for the slave port mux
package ahb_slave_port_mux_pkg;

  localparam int NO_OF_MASTERS_DEF  = 4;
  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    TO_NORMAL = 2'b00,
    TO_ERR1   = 2'b01,
    TO_ERR2   = 2'b10
  } to_state_e;

endpackage

// File: rtl/ahb_onehot_to_index.sv
// rtl/ahb_onehot_to_index.sv - lowest-set-bit priority encoder for the grant vector
module ahb_onehot_to_index #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // scan from the top down so the lowest set bit wins if the vector is not one-hot
  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        index = IDX_W'(i);
      end
    end
  end

  assign any = |onehot;

endmodule

// File: rtl/ahb_slave_port_mux.sv
// rtl/ahb_slave_port_mux.sv - per-slave AHB mux stage; optional wait timeout via AHB_SLAVE_PORT_MUX_TIMEOUT_EN
module ahb_slave_port_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int NO_OF_MASTERS  = NO_OF_MASTERS_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                hclk,
  input  logic                                hresetn,
  input  logic [NO_OF_MASTERS-1:0]            mgrant,
  input  logic [NO_OF_MASTERS-1:0]            mreq,
  input  logic [NO_OF_MASTERS*ADDR_WIDTH-1:0] m_haddr,
  input  logic [NO_OF_MASTERS*2-1:0]          m_htrans,
  input  logic [NO_OF_MASTERS-1:0]            m_hwrite,
  input  logic [NO_OF_MASTERS*3-1:0]          m_hsize,
  input  logic [NO_OF_MASTERS*3-1:0]          m_hburst,
  input  logic [NO_OF_MASTERS-1:0]            m_hmastlock,
  input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0] m_hwdata,
  output logic [NO_OF_MASTERS-1:0]            m_hready,
  output logic [NO_OF_MASTERS-1:0]            m_hresp,
  output logic [DATA_WIDTH-1:0]               m_hrdata,
  output logic                                s_hsel,
  output logic [ADDR_WIDTH-1:0]               s_haddr,
  output logic [1:0]                          s_htrans,
  output logic                                s_hwrite,
  output logic [2:0]                          s_hsize,
  output logic [2:0]                          s_hburst,
  output logic                                s_hmastlock,
  output logic [DATA_WIDTH-1:0]               s_hwdata,
  input  logic                                s_hreadyout,
  input  logic                                s_hresp,
  input  logic [DATA_WIDTH-1:0]               s_hrdata,
  output logic                                timeout
);

  localparam int IDX_W = $clog2(NO_OF_MASTERS);

  if (NO_OF_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ahb_slave_port_mux: NO_OF_MASTERS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [IDX_W-1:0] sel;
  logic             ap_valid;
  logic [IDX_W-1:0] ap_sel_q, ap_sel_d;
  logic             ap_valid_q, ap_valid_d;
  logic             dp_valid_q, dp_valid_d;
  logic [IDX_W-1:0] dp_owner_q, dp_owner_d;
  // slave_rdy is the slave's HREADYOUT as seen by the mux; it is masked while a timeout response runs
  logic             slave_rdy;
  logic             err1;
  logic             err2;

  ahb_onehot_to_index #(
    .WIDTH (NO_OF_MASTERS),
    .IDX_W (IDX_W)
  ) u_grant_enc (
    .onehot (mgrant),
    .index  (grant_idx),
    .any    (grant_any)
  );

`ifdef AHB_SLAVE_PORT_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  to_state_e        to_state_q, to_state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  // count slave wait states on an open data phase and launch the two-cycle error response
  always_comb begin
    to_state_d = to_state_q;
    wait_cnt_d = '0;
    timeout_d  = 1'b0;
    case (to_state_q)
      TO_NORMAL: begin
        if (dp_valid_q && !s_hreadyout) begin
          if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            to_state_d = TO_ERR1;
            timeout_d  = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      TO_ERR1: to_state_d = TO_ERR2;
      TO_ERR2: to_state_d = TO_NORMAL;
      default: to_state_d = TO_NORMAL;
    endcase
  end

  // timeout FSM state, wait counter and registered pulse
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      to_state_q <= TO_NORMAL;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      to_state_q <= to_state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign err1      = (to_state_q == TO_ERR1);
  assign err2      = (to_state_q == TO_ERR2);
  assign slave_rdy = s_hreadyout && (to_state_q == TO_NORMAL);
  assign timeout   = timeout_q;
`else
  assign err1      = 1'b0;
  assign err2      = 1'b0;
  assign slave_rdy = s_hreadyout;
  assign timeout   = 1'b0;
`endif

  // address-phase owner: live grant while the slave is ready, held copy during wait states
  always_comb begin
    if (slave_rdy) begin
      sel      = grant_idx;
      ap_valid = hresetn & grant_any;
    end else begin
      sel      = ap_sel_q;
      ap_valid = hresetn & ap_valid_q;
    end
  end

  // forward the selected master's address/control and the data-phase owner's write data
  always_comb begin
    s_hsel      = ap_valid;
    s_haddr     = '0;
    s_htrans    = HTRANS_IDLE;
    s_hwrite    = 1'b0;
    s_hsize     = 3'b000;
    s_hburst    = 3'b000;
    s_hmastlock = 1'b0;
    if (ap_valid) begin
      s_haddr     = m_haddr[int'(sel) * ADDR_WIDTH +: ADDR_WIDTH];
      s_hwrite    = m_hwrite[sel];
      s_hsize     = m_hsize[int'(sel) * 3 +: 3];
      s_hburst    = m_hburst[int'(sel) * 3 +: 3];
      s_hmastlock = m_hmastlock[sel];
      if (!err1) begin
        s_htrans = m_htrans[int'(sel) * 2 +: 2];
      end
    end
    s_hwdata = dp_valid_q ? m_hwdata[int'(dp_owner_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // advance address and data phase on every slave-ready cycle; a timeout closes the data phase
  always_comb begin
    ap_sel_d   = ap_sel_q;
    ap_valid_d = ap_valid_q;
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;
    if (slave_rdy) begin
      ap_sel_d   = grant_idx;
      ap_valid_d = grant_any;
      dp_valid_d = ap_valid && s_htrans[1];
      dp_owner_d = sel;
    end
    if (err2) begin
      dp_valid_d = 1'b0;
    end
  end

  // phase tracking registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ap_sel_q   <= '0;
      ap_valid_q <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_owner_q <= '0;
    end else begin
      ap_sel_q   <= ap_sel_d;
      ap_valid_q <= ap_valid_d;
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
    end
  end

  // route HREADY/HRESP to the data-phase owner and stall requesters that do not own the address phase
  always_comb begin
    m_hready = '1;
    m_hresp  = '0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (dp_valid_q && dp_owner_q == IDX_W'(i)) begin
        if (err1) begin
          m_hready[i] = 1'b0;
          m_hresp[i]  = HRESP_ERROR;
        end else if (err2) begin
          m_hready[i] = 1'b1;
          m_hresp[i]  = HRESP_ERROR;
        end else begin
          m_hready[i] = s_hreadyout;
          m_hresp[i]  = s_hresp;
        end
      end else if (hresetn && mreq[i] && !(ap_valid && sel == IDX_W'(i))) begin
        m_hready[i] = 1'b0;
      end
    end
  end

  assign m_hrdata = hresetn ? s_hrdata : '0;

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// tb/tb_ahb_slave_port_mux.sv - scoreboard bench for ahb_slave_port_mux
module tb_ahb_slave_port_mux;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam int SIG_S_HSEL   = 0;
  localparam int SIG_S_HADDR  = 1;
  localparam int SIG_S_HTRANS = 2;
  localparam int SIG_S_HWRITE = 3;
  localparam int SIG_S_HWDATA = 4;
  localparam int SIG_M_HREADY = 5;
  localparam int SIG_M_HRESP  = 6;
  localparam int SIG_M_HRDATA = 7;
  localparam int SIG_TIMEOUT  = 8;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [N-1:0]    mgrant, mreq;
  logic [N*AW-1:0] m_haddr;
  logic [N*2-1:0]  m_htrans;
  logic [N-1:0]    m_hwrite;
  logic [N*3-1:0]  m_hsize, m_hburst;
  logic [N-1:0]    m_hmastlock;
  logic [N*DW-1:0] m_hwdata;
  logic [N-1:0]    m_hready, m_hresp;
  logic [DW-1:0]   m_hrdata;
  logic            s_hsel;
  logic [AW-1:0]   s_haddr;
  logic [1:0]      s_htrans;
  logic            s_hwrite;
  logic [2:0]      s_hsize, s_hburst;
  logic            s_hmastlock;
  logic [DW-1:0]   s_hwdata;
  logic            s_hreadyout, s_hresp;
  logic [DW-1:0]   s_hrdata;
  logic            timeout;

  ahb_slave_port_mux #(
    .NO_OF_MASTERS  (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .mgrant      (mgrant),
    .mreq        (mreq),
    .m_haddr     (m_haddr),
    .m_htrans    (m_htrans),
    .m_hwrite    (m_hwrite),
    .m_hsize     (m_hsize),
    .m_hburst    (m_hburst),
    .m_hmastlock (m_hmastlock),
    .m_hwdata    (m_hwdata),
    .m_hready    (m_hready),
    .m_hresp     (m_hresp),
    .m_hrdata    (m_hrdata),
    .s_hsel      (s_hsel),
    .s_haddr     (s_haddr),
    .s_htrans    (s_htrans),
    .s_hwrite    (s_hwrite),
    .s_hsize     (s_hsize),
    .s_hburst    (s_hburst),
    .s_hmastlock (s_hmastlock),
    .s_hwdata    (s_hwdata),
    .s_hreadyout (s_hreadyout),
    .s_hresp     (s_hresp),
    .s_hrdata    (s_hrdata),
    .timeout     (timeout)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cur_cyc = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   done    = 1'b0;

  always @(posedge hclk) cur_cyc = cur_cyc + 1;

  function automatic logic [63:0] observe(int s);
    case (s)
      SIG_S_HSEL:   return 64'(s_hsel);
      SIG_S_HADDR:  return 64'(s_haddr);
      SIG_S_HTRANS: return 64'(s_htrans);
      SIG_S_HWRITE: return 64'(s_hwrite);
      SIG_S_HWDATA: return 64'(s_hwdata);
      SIG_M_HREADY: return 64'(m_hready);
      SIG_M_HRESP:  return 64'(m_hresp);
      SIG_M_HRDATA: return 64'(m_hrdata);
      SIG_TIMEOUT:  return 64'(timeout);
      default:      return '1;
    endcase
  endfunction

  // monitor: pop every expectation due this cycle and compare against the DUT on the falling edge
  always @(negedge hclk) begin
    exp_t        e;
    logic [63:0] got;
    while (sb.size() > 0 && sb[0].cyc <= cur_cyc) begin
      e   = sb.pop_front();
      got = observe(e.sig);
      checks = checks + 1;
      if (e.cyc != cur_cyc) begin
        errors = errors + 1;
        $display("FAIL %s stale entry for cycle %0d seen at %0d", e.name, e.cyc, cur_cyc);
      end else if (got !== e.val) begin
        errors = errors + 1;
        $display("FAIL %s cycle %0d got %0h expected %0h", e.name, cur_cyc, got, e.val);
      end
    end
    if (done) begin
      checks = checks + 1;
      if (sb.size() != 0) begin
        errors = errors + 1;
        $display("FAIL scoreboard_drain got %0d entries left expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic exp_push(int sig, logic [63:0] v, string n);
    sb.push_back('{cur_cyc, sig, v, n});
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_m(int i, logic [AW-1:0] a, logic [1:0] t, logic w);
    m_haddr[i*AW +: AW] = a;
    m_htrans[i*2 +: 2]  = t;
    m_hwrite[i]         = w;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drive_m(i, '0, 2'b00, 1'b0);
    mgrant = '0;
    mreq   = '0;
  endtask

  initial begin
    hresetn     = 1'b0;
    m_hsize     = '0;
    m_hburst    = '0;
    m_hmastlock = '0;
    m_hwdata    = {32'h33333333, 32'h22222222, 32'h11111111, 32'hA5A5A5A5};
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
    s_hrdata    = 32'hDEADBEEF;
    idle_all();
    mgrant = 4'b0001;
    mreq   = 4'b0001;
    drive_m(0, 32'h10, 2'b10, 1'b1);

    // reset holds every output at its idle value despite an active request
    step();
    exp_push(SIG_S_HSEL,   0,     "rst_s_hsel");
    exp_push(SIG_S_HTRANS, 0,     "rst_s_htrans");
    exp_push(SIG_S_HADDR,  0,     "rst_s_haddr");
    exp_push(SIG_S_HWDATA, 0,     "rst_s_hwdata");
    exp_push(SIG_M_HREADY, 4'hF,  "rst_m_hready");
    exp_push(SIG_M_HRESP,  0,     "rst_m_hresp");
    exp_push(SIG_M_HRDATA, 0,     "rst_m_hrdata");
    exp_push(SIG_TIMEOUT,  0,     "rst_timeout");

    // single write from master 0
    step();
    hresetn = 1'b1;
    exp_push(SIG_S_HSEL,   1,            "wr_s_hsel");
    exp_push(SIG_S_HADDR,  32'h10,       "wr_s_haddr");
    exp_push(SIG_S_HTRANS, 2'b10,        "wr_s_htrans");
    exp_push(SIG_S_HWRITE, 1,            "wr_s_hwrite");
    exp_push(SIG_S_HWDATA, 0,            "wr_ap_hwdata");
    exp_push(SIG_M_HREADY, 4'hF,         "wr_ap_hready");
    exp_push(SIG_M_HRDATA, 32'hDEADBEEF, "wr_hrdata_bcast");
    step();
    idle_all();
    exp_push(SIG_S_HWDATA, 32'hA5A5A5A5, "wr_dp_hwdata");
    exp_push(SIG_M_HREADY, 4'hF,         "wr_dp_hready");
    exp_push(SIG_S_HSEL,   0,            "wr_idle_hsel");
    exp_push(SIG_S_HTRANS, 0,            "wr_idle_htrans");
    step();
    exp_push(SIG_S_HWDATA, 0,            "wr_after_hwdata");

    // contention: master 0 stalled while master 1 owns the address phase
    step();
    mreq   = 4'b0011;
    mgrant = 4'b0010;
    drive_m(0, 32'h10, 2'b10, 1'b0);
    drive_m(1, 32'h20, 2'b10, 1'b1);
    exp_push(SIG_S_HADDR,  32'h20, "ct_m1_haddr");
    exp_push(SIG_M_HREADY, 4'hE,   "ct_m0_stall");
    step();
    mreq   = 4'b0001;
    mgrant = 4'b0001;
    drive_m(1, 32'h0, 2'b00, 1'b0);
    exp_push(SIG_S_HADDR,  32'h10,       "ct_m0_haddr");
    exp_push(SIG_S_HWRITE, 0,            "ct_m0_read");
    exp_push(SIG_S_HWDATA, 32'h11111111, "ct_m1_hwdata");
    exp_push(SIG_M_HREADY, 4'hF,         "ct_hready");

    // three wait states while the grant moves to master 2
    for (int k = 0; k < 3; k++) begin
      step();
      s_hreadyout = 1'b0;
      s_hrdata    = 32'h12345678;
      mgrant      = 4'b0100;
      mreq        = 4'b0101;
      drive_m(0, 32'h14, 2'b10, 1'b0);
      drive_m(2, 32'h30, 2'b10, 1'b0);
      exp_push(SIG_S_HADDR,  32'h14,       $sformatf("ws%0d_haddr_held", k));
      exp_push(SIG_M_HREADY, 4'hA,         $sformatf("ws%0d_hready", k));
      exp_push(SIG_S_HWDATA, 32'hA5A5A5A5, $sformatf("ws%0d_hwdata", k));
      exp_push(SIG_M_HRDATA, 32'h12345678, $sformatf("ws%0d_hrdata", k));
    end
    step();
    s_hreadyout = 1'b1;
    exp_push(SIG_S_HADDR,  32'h30, "ws_release_haddr");
    exp_push(SIG_M_HREADY, 4'hF,   "ws_release_hready");
    step();
    idle_all();
    exp_push(SIG_S_HWDATA, 32'h22222222, "ws_m2_hwdata");
    exp_push(SIG_S_HSEL,   0,            "ws_idle_hsel");

    // two-cycle slave ERROR on master 1
    step();
    mgrant = 4'b0010;
    mreq   = 4'b0010;
    drive_m(1, 32'h24, 2'b10, 1'b1);
    exp_push(SIG_S_HADDR, 32'h24, "er_haddr");
    step();
    idle_all();
    s_hresp     = 1'b1;
    s_hreadyout = 1'b0;
    exp_push(SIG_M_HREADY, 4'hD, "er1_hready");
    exp_push(SIG_M_HRESP,  4'h2, "er1_hresp");
    step();
    s_hreadyout = 1'b1;
    exp_push(SIG_M_HREADY, 4'hF, "er2_hready");
    exp_push(SIG_M_HRESP,  4'h2, "er2_hresp");
    step();
    s_hresp = 1'b0;
    exp_push(SIG_M_HRESP, 0, "er_done_hresp");

    // BUSY opens no data phase, so a slave error afterwards reaches nobody
    step();
    mgrant = 4'b0001;
    mreq   = 4'b0001;
    drive_m(0, 32'h18, 2'b01, 1'b1);
    exp_push(SIG_S_HTRANS, 2'b01, "busy_htrans");
    exp_push(SIG_S_HSEL,   1,     "busy_hsel");
    step();
    idle_all();
    s_hresp     = 1'b1;
    s_hreadyout = 1'b0;
    exp_push(SIG_S_HWDATA, 0,    "busy_no_dp_hwdata");
    exp_push(SIG_M_HREADY, 4'hF, "busy_no_dp_hready");
    exp_push(SIG_M_HRESP,  0,    "busy_no_dp_hresp");
    step();
    s_hresp     = 1'b0;
    s_hreadyout = 1'b1;

    // non one-hot grant selects the lowest set bit
    step();
    mgrant = 4'b1010;
    drive_m(1, 32'h28, 2'b10, 1'b0);
    drive_m(3, 32'h40, 2'b10, 1'b1);
    exp_push(SIG_S_HADDR, 32'h28, "lsb_haddr");
    step();
    idle_all();
    exp_push(SIG_S_HWDATA, 32'h11111111, "lsb_hwdata");

    // reset in the middle of a write data phase
    step();
    mgrant = 4'b0001;
    mreq   = 4'b0001;
    drive_m(0, 32'h1C, 2'b10, 1'b1);
    exp_push(SIG_S_HADDR, 32'h1C, "rm_haddr");
    step();
    hresetn = 1'b0;
    exp_push(SIG_S_HSEL,   0,    "rm_hsel");
    exp_push(SIG_S_HTRANS, 0,    "rm_htrans");
    exp_push(SIG_S_HWDATA, 0,    "rm_hwdata");
    exp_push(SIG_M_HREADY, 4'hF, "rm_hready");
    exp_push(SIG_M_HRDATA, 0,    "rm_hrdata");
    step();
    hresetn = 1'b1;
    idle_all();
    exp_push(SIG_S_HWDATA, 0, "rm_dropped_hwdata");
    exp_push(SIG_M_HRESP,  0, "rm_dropped_hresp");

    // slave stalls a write indefinitely
    step();
    mgrant = 4'b0001;
    mreq   = 4'b0001;
    drive_m(0, 32'h10, 2'b10, 1'b1);
    exp_push(SIG_S_HADDR, 32'h10, "to_haddr");
    for (int k = 0; k < 7; k++) begin
      logic [3:0] e_rdy, e_resp;
      logic       e_to;
      step();
      idle_all();
      s_hreadyout = 1'b0;
      e_rdy  = 4'hE;
      e_resp = 4'h0;
      e_to   = 1'b0;
`ifdef AHB_SLAVE_PORT_MUX_TIMEOUT_EN
      if (k == 4) begin
        e_resp = 4'h1;
        e_to   = 1'b1;
      end else if (k == 5) begin
        e_rdy  = 4'hF;
        e_resp = 4'h1;
      end else if (k == 6) begin
        e_rdy  = 4'hF;
      end
`endif
      exp_push(SIG_M_HREADY, 64'(e_rdy),  $sformatf("to%0d_hready", k));
      exp_push(SIG_M_HRESP,  64'(e_resp), $sformatf("to%0d_hresp", k));
      exp_push(SIG_TIMEOUT,  64'(e_to),   $sformatf("to%0d_timeout", k));
      exp_push(SIG_S_HTRANS, 0,           $sformatf("to%0d_htrans", k));
    end
`ifdef AHB_SLAVE_PORT_MUX_TIMEOUT_EN
    exp_push(SIG_S_HWDATA, 0, "to_dp_closed");
`else
    exp_push(SIG_S_HWDATA, 32'hA5A5A5A5, "to_dp_open");
`endif
    step();
    s_hreadyout = 1'b1;
    step();
    exp_push(SIG_M_HREADY, 4'hF, "end_hready");
    exp_push(SIG_TIMEOUT,  0,    "end_timeout");
    step();
    done = 1'b1;
  end

endmodule
